// File: rtl/toy_pack.sv
// Shared sizing for the BPU reorder-buffer controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package toy_pack;

  localparam int ROB_DEPTH     = 8;
  localparam int ROB_PTR_WIDTH = $clog2(ROB_DEPTH) + 1;

endpackage

// File: rtl/toy_bpu_rob_ptr.sv
// Wrap-bit ring pointer with increment and parallel load (load wins).
// Latency: new value visible one cycle after inc/load.
// Backpressure: none; caller qualifies inc.
module toy_bpu_rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  // Pointer register: load takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/toy_bpu_rob_ctrl.sv
// ROB pointer control for fetch: allocate, ack, BP2 predict, release to filter.
// Latency: one-hot strobes are combinational; pointers advance next cycle.
// Backpressure: icache_req_rdy drops when full vs. rd or ack; filter_rdy stalls release.
module toy_bpu_rob_ctrl #(
  parameter int ROB_DEPTH = toy_pack::ROB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         icache_req_vld,
  output logic                         icache_req_rdy,
  input  logic                         icache_ack_vld,
  input  logic                         bp2_vld,
  input  logic                         bp2_flush,
  input  logic                         fe_ctrl_flush,
  input  logic [ROB_DEPTH-1:0]         entry_wait_0,
  input  logic [ROB_DEPTH-1:0]         entry_valid,
  input  logic [ROB_DEPTH-1:0]         entry_invalid,
  output logic [ROB_DEPTH-1:0]         entry_prealloc,
  output logic [ROB_DEPTH-1:0]         entry_ack_vld,
  output logic [ROB_DEPTH-1:0]         entry_bp2_vld,
  output logic [ROB_DEPTH-1:0]         entry_bp2_flush,
  output logic [ROB_DEPTH-1:0]         entry_rden,
  output logic [ROB_DEPTH-1:0]         entry_bypass,
  output logic                         filter_vld,
  input  logic                         filter_rdy,
  output logic [$clog2(ROB_DEPTH)-1:0] filter_idx
);

  import toy_pack::*;

  localparam int IW = $clog2(ROB_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0]        DEPTH_P = PW'(ROB_DEPTH);
  localparam logic [ROB_DEPTH-1:0] ONE     = ROB_DEPTH'(1);

  logic [PW-1:0] wr_ptr, ack_ptr, bp2_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, occ_rd, occ_ack;
  logic [IW-1:0] wr_idx, ack_idx, bp2_idx, rd_idx;
  logic          full, alloc, bp2_fire, has_rd, rden, bypass;

  assign wr_idx  = wr_ptr[IW-1:0];
  assign ack_idx = ack_ptr[IW-1:0];
  assign bp2_idx = bp2_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];

  // Full against either the release side or outstanding acks: a slot is only
  // reusable once its ack has come back and it has been released.
  assign occ_rd         = wr_ptr - rd_ptr;
  assign occ_ack        = wr_ptr - ack_ptr;
  assign full           = (occ_rd == DEPTH_P) || (occ_ack == DEPTH_P);
  assign icache_req_rdy = !full;
  assign alloc          = icache_req_vld && !full;
  assign wr_ptr_nxt     = wr_ptr + PW'(alloc);
  assign filter_idx     = rd_idx;

  // Event qualification and one-hot strobes; flush kills the BP2 and release side.
  always_comb begin
    entry_prealloc  = '0;
    entry_ack_vld   = '0;
    entry_bp2_vld   = '0;
    entry_bp2_flush = '0;
    entry_rden      = '0;
    entry_bypass    = '0;
    filter_vld      = 1'b0;
    has_rd          = (rd_ptr != bp2_ptr);
    bp2_fire        = bp2_vld && !fe_ctrl_flush && (bp2_ptr != wr_ptr);
    // Bypass needs an invalid entry, so it can never coincide with filter_vld.
    bypass          = !fe_ctrl_flush && has_rd && entry_invalid[rd_idx] && !entry_wait_0[rd_idx];
    filter_vld      = !fe_ctrl_flush && has_rd && entry_valid[rd_idx] && !entry_invalid[rd_idx];
    rden            = filter_vld && filter_rdy;
    if (alloc)                 entry_prealloc  = ONE << wr_idx;
    if (icache_ack_vld)        entry_ack_vld   = ONE << ack_idx;
    if (bp2_fire)              entry_bp2_vld   = ONE << bp2_idx;
    if (bp2_fire && bp2_flush) entry_bp2_flush = ONE << bp2_idx;
    if (rden)                  entry_rden      = ONE << rd_idx;
    if (bypass)                entry_bypass    = ONE << rd_idx;
  end

  toy_bpu_rob_ptr #(.W(PW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .inc(alloc), .load(1'b0), .load_val('0), .ptr(wr_ptr)
  );

  // Ack pointer keeps counting through flushes so late acks land in their old slots.
  toy_bpu_rob_ptr #(.W(PW)) u_ack_ptr (
    .clk(clk), .rst_n(rst_n), .inc(icache_ack_vld), .load(1'b0), .load_val('0), .ptr(ack_ptr)
  );

  toy_bpu_rob_ptr #(.W(PW)) u_bp2_ptr (
    .clk(clk), .rst_n(rst_n), .inc(bp2_fire), .load(fe_ctrl_flush), .load_val(wr_ptr_nxt),
    .ptr(bp2_ptr)
  );

  toy_bpu_rob_ptr #(.W(PW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .inc(rden || bypass), .load(fe_ctrl_flush), .load_val(wr_ptr_nxt),
    .ptr(rd_ptr)
  );

endmodule

// File: tb/tb_toy_bpu_rob_ctrl.sv
// Directed bench for toy_bpu_rob_ctrl with a release-order scoreboard.
// Latency: checks strobes 2ns after driving, pointers one cycle later.
// Backpressure: exercises full on both rd and ack sides.
module tb_toy_bpu_rob_ctrl;

  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         icache_req_vld, icache_req_rdy, icache_ack_vld;
  logic         bp2_vld, bp2_flush, fe_ctrl_flush;
  logic [D-1:0] entry_wait_0, entry_valid, entry_invalid;
  logic [D-1:0] entry_prealloc, entry_ack_vld, entry_bp2_vld, entry_bp2_flush;
  logic [D-1:0] entry_rden, entry_bypass;
  logic         filter_vld, filter_rdy;
  logic [2:0]   filter_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int q[$];

  always #5 clk = ~clk;

  toy_bpu_rob_ctrl #(.ROB_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req_vld(icache_req_vld), .icache_req_rdy(icache_req_rdy),
    .icache_ack_vld(icache_ack_vld),
    .bp2_vld(bp2_vld), .bp2_flush(bp2_flush), .fe_ctrl_flush(fe_ctrl_flush),
    .entry_wait_0(entry_wait_0), .entry_valid(entry_valid), .entry_invalid(entry_invalid),
    .entry_prealloc(entry_prealloc), .entry_ack_vld(entry_ack_vld),
    .entry_bp2_vld(entry_bp2_vld), .entry_bp2_flush(entry_bp2_flush),
    .entry_rden(entry_rden), .entry_bypass(entry_bypass),
    .filter_vld(filter_vld), .filter_rdy(filter_rdy), .filter_idx(filter_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] oh(input int i);
    logic [D-1:0] v;
    v = 8'h01;
    return v << (i % D);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_req_vld = 1'b0; icache_ack_vld = 1'b0;
    bp2_vld = 1'b0; bp2_flush = 1'b0; fe_ctrl_flush = 1'b0;
    entry_wait_0 = '0; entry_valid = '0; entry_invalid = '0;
    filter_rdy = 1'b0;
  endtask

  task automatic chk_ptrs(input string tag, input int wr, input int ack, input int bp2, input int rd);
    chk({tag, "_wr"},  64'(dut.wr_ptr),  64'(wr));
    chk({tag, "_ack"}, 64'(dut.ack_ptr), 64'(ack));
    chk({tag, "_bp2"}, 64'(dut.bp2_ptr), 64'(bp2));
    chk({tag, "_rd"},  64'(dut.rd_ptr),  64'(rd));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    chk_ptrs("rst", 0, 0, 0, 0);
    chk("rst_rdy", 64'(icache_req_rdy), 64'd1);
    chk("rst_outs", 64'({entry_prealloc, entry_ack_vld, entry_bp2_vld, entry_bp2_flush,
                         entry_rden, entry_bypass, filter_vld}), 64'd0);
    cyc();
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic alloc_step(input int idx, input logic exp_rdy);
    icache_req_vld = 1'b1;
    #2;
    chk("alloc_rdy", 64'(icache_req_rdy), 64'(exp_rdy));
    chk("alloc_prealloc", 64'(entry_prealloc), exp_rdy ? 64'(oh(idx)) : 64'd0);
    if (exp_rdy) q.push_back(idx);
    cyc();
    icache_req_vld = 1'b0;
  endtask

  // Allocate, then ack+predict, then release through the filter.
  task automatic triple(input int idx);
    int exp;
    alloc_step(idx, 1'b1);
    icache_ack_vld = 1'b1; bp2_vld = 1'b1;
    #2;
    chk("tri_ack", 64'(entry_ack_vld), 64'(oh(idx)));
    chk("tri_bp2", 64'(entry_bp2_vld), 64'(oh(idx)));
    chk("tri_fvld_early", 64'(filter_vld), 64'd0);
    cyc();
    icache_ack_vld = 1'b0; bp2_vld = 1'b0;
    entry_valid = oh(idx); filter_rdy = 1'b1;
    #2;
    exp = (q.size() > 0) ? q.pop_front() : -1;
    chk("tri_fvld", 64'(filter_vld), 64'd1);
    chk("tri_fidx", 64'(filter_idx), 64'(exp));
    chk("tri_rden", 64'(entry_rden), 64'(oh(exp)));
    chk("tri_quiet", 64'({entry_prealloc, entry_ack_vld, entry_bp2_vld, entry_bp2_flush,
                          entry_bypass}), 64'd0);
    cyc();
    entry_valid = '0; filter_rdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #1;
    do_reset();

    // Full after 8 allocations; one ack alone does not reopen.
    for (int i = 0; i < 8; i++) alloc_step(i, 1'b1);
    alloc_step(8, 1'b0);
    icache_ack_vld = 1'b1;
    #2;
    chk("full_ack", 64'(entry_ack_vld), 64'h01);
    cyc();
    icache_ack_vld = 1'b0;
    #2;
    chk("full_after_ack", 64'(icache_req_rdy), 64'd0);
    bp2_vld = 1'b1;
    #2;
    chk("full_bp2", 64'(entry_bp2_vld), 64'h01);
    cyc();
    bp2_vld = 1'b0;
    entry_invalid = 8'h01;
    #2;
    chk("full_bypass", 64'(entry_bypass), 64'h01);
    chk("full_bypass_fvld", 64'(filter_vld), 64'd0);
    cyc();
    entry_invalid = '0;
    #2;
    chk("full_reopen", 64'(icache_req_rdy), 64'd1);
    chk_ptrs("full_end", 8, 1, 1, 1);

    // Single entry through filter.
    do_reset();
    triple(0);
    chk("rd_after_rden", 64'(dut.rd_ptr), 64'd1);

    // BP2 flush on entry 2, then bypass.
    do_reset();
    for (int i = 0; i < 3; i++) alloc_step(i, 1'b1);
    icache_ack_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("c_ack", 64'(entry_ack_vld), 64'(oh(i)));
      cyc();
    end
    icache_ack_vld = 1'b0;
    bp2_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("c_bp2", 64'(entry_bp2_vld), 64'(oh(i)));
      cyc();
    end
    bp2_vld = 1'b0;
    entry_valid = 8'h03; filter_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("c_rden", 64'(entry_rden), 64'(oh(q.size() > 0 ? q.pop_front() : 9)));
      cyc();
    end
    entry_valid = '0; filter_rdy = 1'b0;
    bp2_vld = 1'b1; bp2_flush = 1'b1;
    #2;
    chk("c_bp2_flush", 64'(entry_bp2_flush), 64'h04);
    chk("c_bp2_vld", 64'(entry_bp2_vld), 64'h04);
    cyc();
    bp2_vld = 1'b0; bp2_flush = 1'b0;
    entry_valid = 8'h04; entry_invalid = 8'h04;
    #2;
    chk("c_bypass", 64'(entry_bypass), 64'(oh(q.size() > 0 ? q.pop_front() : 9)));
    chk("c_bypass_fvld", 64'(filter_vld), 64'd0);
    chk("c_bypass_rden", 64'(entry_rden), 64'd0);
    cyc();
    entry_valid = '0; entry_invalid = '0;
    chk("c_rd", 64'(dut.rd_ptr), 64'd3);

    // Frontend flush with 3 entries awaiting ack; alloc in the flush cycle.
    do_reset();
    for (int i = 0; i < 3; i++) alloc_step(i, 1'b1);
    fe_ctrl_flush = 1'b1; icache_req_vld = 1'b1; bp2_vld = 1'b1;
    #2;
    chk("d_flush_prealloc", 64'(entry_prealloc), 64'h08);
    chk("d_flush_bp2", 64'(entry_bp2_vld), 64'd0);
    chk("d_flush_fvld", 64'(filter_vld), 64'd0);
    cyc();
    clear_inputs();
    chk_ptrs("d_flush", 4, 0, 4, 4);
    for (int i = 4; i < 8; i++) alloc_step(i, 1'b1);
    icache_req_vld = 1'b1;
    #2;
    chk("d_full", 64'(icache_req_rdy), 64'd0);
    icache_req_vld = 1'b0;
    icache_ack_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("d_ack_old_slot", 64'(entry_ack_vld), 64'(oh(i)));
      cyc();
      chk("d_rdy_after_ack", 64'(icache_req_rdy), 64'd1);
    end
    icache_ack_vld = 1'b0;
    chk("d_ack_ptr", 64'(dut.ack_ptr), 64'd3);

    // Wrap-around run of 20 triples.
    do_reset();
    for (int i = 0; i < 20; i++) triple(i % D);
    chk_ptrs("e_end", 20 % 16, 20 % 16, 20 % 16, 20 % 16);

    // Reset mid-operation with pointers at 5.
    do_reset();
    for (int i = 0; i < 5; i++) triple(i);
    chk_ptrs("f_pre", 5, 5, 5, 5);
    #3;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk_ptrs("f_rst", 0, 0, 0, 0);
    chk("f_rst_rdy", 64'(icache_req_rdy), 64'd1);
    chk("f_rst_fvld", 64'(filter_vld), 64'd0);
    cyc();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
